ext_line_memory_responder: RTL

Responder end of the external cache-line memory interface driven by the unified memory controller: accepts one line-wide read or write request at a time over the `mem_req`/`mem_ack` handshake and answers with a single-cycle acknowledge after a modelled DRAM latency. It backs the line interface with a local line store and single open-row tracking. It also keeps read and write transaction counters. It sits outside the system top, on the `mem_*` pins, as the memory model for simulation and FPGA bring-up.

---
 rtl/ext_mem_pkg.sv | 31 +++
 rtl/ext_line_store.sv | 36 +++
 rtl/ext_line_memory_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ext_mem_pkg.sv
// Shared types and helpers for the external cache-line memory responder.
package ext_mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      ACK     = 2'd2,
      RECOVER = 2'd3
   } ext_mem_state_t;

   localparam int LINE_BYTES = 512 / 8;

   function automatic int offset_shift(input int line_width);
      return $clog2(line_width / 8);
   endfunction

   function automatic int row_shift(input int row_lines);
      return $clog2(row_lines);
   endfunction

   function automatic int sel_latency(input logic we, input logic row_hit,
                                      input int rd_lat, input int hit_lat,
                                      input int wr_lat);
      if (we)
         return wr_lat;
      else if (row_hit)
         return hit_lat;
      return rd_lat;
   endfunction

endpackage

// File: rtl/ext_line_store.sv
// Single-port line array; synchronous write, registered read at the commit edge.
// Only the read register is cleared (i_clr); the array itself is never initialised.
module ext_line_store
   import ext_mem_pkg::*;
#(
   parameter int W     = 512,
   parameter int DEPTH = 256,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_we,
   input  logic             i_re,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [W-1:0]     i_wdata,
   output logic [W-1:0]     o_rdata
);

   logic [W-1:0] r_mem [DEPTH];
   logic [W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_idx] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (i_clr)
         r_rdata <= '0;
      else if (i_re)
         r_rdata <= r_mem[i_idx];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/ext_line_memory_responder.sv
// Memory-model responder on the mem_* line interface: one request at a time,
// DRAM-like latency with single open-row tracking, read/write counters.
module ext_line_memory_responder
   import ext_mem_pkg::*;
#(
   parameter int CACHE_LINE_WIDTH = 512,
   parameter int ADDR_WIDTH       = 32,
   parameter int DEPTH_LINES      = 256,
   parameter int ROW_LINES        = 16,
   parameter int READ_LATENCY     = 8,
   parameter int ROW_HIT_LATENCY  = 3,
   parameter int WRITE_LATENCY    = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [ADDR_WIDTH-1:0]       mem_addr,
   input  logic [CACHE_LINE_WIDTH-1:0] mem_wdata,
   output logic [CACHE_LINE_WIDTH-1:0] mem_rdata,
   input  logic                        mem_req,
   input  logic                        mem_we,
   output logic                        mem_ack,
   output logic                        busy,
   output logic [31:0]                 rd_count,
   output logic [31:0]                 wr_count
);

   localparam int OFF_SH  = offset_shift(CACHE_LINE_WIDTH);
   localparam int IDX_W   = $clog2(DEPTH_LINES);
   localparam int ROW_SH  = row_shift(ROW_LINES);
   localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   ext_mem_state_t              r_state, w_next;
   logic [CNT_W-1:0]            r_cnt, w_cnt_next;
   logic [IDX_W-1:0]            r_idx, r_open_row;
   logic                        r_row_valid, r_we, r_ack, r_busy;
   logic [CACHE_LINE_WIDTH-1:0] r_wdata;
   logic [31:0]                 r_rd_count, r_wr_count;

   logic [IDX_W-1:0]            w_req_idx, w_req_row, w_commit_idx;
   logic                        w_row_hit, w_accept, w_commit, w_commit_we;
   logic [CACHE_LINE_WIDTH-1:0] w_commit_wdata;
   int                          w_lat;
   logic                        w_unused_addr;

   // Upper address bits beyond the store alias onto lower lines by truncation.
   assign w_req_idx     = mem_addr[OFF_SH +: IDX_W];
   assign w_req_row     = w_req_idx >> ROW_SH;
   assign w_row_hit     = r_row_valid && (w_req_row == r_open_row);
   assign w_lat         = sel_latency(mem_we, w_row_hit, READ_LATENCY,
                                      ROW_HIT_LATENCY, WRITE_LATENCY);
   assign w_unused_addr = ^mem_addr;

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_accept   = 1'b0;
      w_commit   = 1'b0;
      case (r_state)
         IDLE: begin
            if (mem_req) begin
               w_accept = 1'b1;
               if (w_lat == 1) begin
                  w_next   = ACK;
                  w_commit = 1'b1;
               end else begin
                  w_next     = WAIT;
                  w_cnt_next = CNT_W'(w_lat - 1);
               end
            end
         end
         WAIT: begin
            w_cnt_next = r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
               w_next   = ACK;
               w_commit = 1'b1;
            end
         end
         ACK:     w_next = RECOVER;
         RECOVER: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // A latency-1 transaction commits on its accepting edge, before the latch is loaded.
   assign w_commit_idx   = w_accept ? w_req_idx : r_idx;
   assign w_commit_we    = w_accept ? mem_we    : r_we;
   assign w_commit_wdata = w_accept ? mem_wdata : r_wdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_row_valid <= 1'b0;
         r_ack       <= 1'b0;
         r_busy      <= 1'b0;
         r_rd_count  <= '0;
         r_wr_count  <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         r_ack   <= (w_next == ACK);
         r_busy  <= (w_next != IDLE);
         if (w_accept)
            r_row_valid <= 1'b1;
         if (w_commit && w_commit_we)
            r_wr_count <= r_wr_count + 32'd1;
         if (w_commit && !w_commit_we)
            r_rd_count <= r_rd_count + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_idx      <= w_req_idx;
         r_we       <= mem_we;
         r_wdata    <= mem_wdata;
         r_open_row <= w_req_row;
      end
   end

   ext_line_store #(
      .W     (CACHE_LINE_WIDTH),
      .DEPTH (DEPTH_LINES),
      .IDX_W (IDX_W)
   ) u_store (
      .clk     (clk),
      .i_clr   (!rst_n),
      .i_we    (rst_n && w_commit && w_commit_we),
      .i_re    (rst_n && w_commit && !w_commit_we),
      .i_idx   (w_commit_idx),
      .i_wdata (w_commit_wdata),
      .o_rdata (mem_rdata)
   );

   assign mem_ack  = r_ack;
   assign busy     = r_busy;
   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;

endmodule
